dense_layer_seq: RTL and testbench
==================================

Name: dense_layer_seq

Overview:
- Parametrised, time-multiplexed fully-connected layer engine.
- Streams in an activation vector, computes OUT_SIZE neurons with one multiply-accumulate per cycle, and streams out results over a valid/ready handshake.
- Weights and biases come from external synchronous memories.
- Replaces the fully-combinational per-layer datapath; one instance per network layer, chained output-to-input.

Parameters:
- IN_SIZE, 64: input vector length.
- OUT_SIZE, 32: neuron count.
- DATA_W, 16: signed activation, weight and bias width.
- FRAC_BITS, 8: fixed-point fraction bits.
- ACC_W, 40: signed accumulator width.
- RELU, 1: 1 applies ReLU to outputs; 0 passes values through linearly.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high only in IDLE.
- in_data  in  DATA_W  signed input sample; index order 0..IN_SIZE-1.
- w_addr  out  clog2(IN_SIZE*OUT_SIZE)  weight address, row-major: neuron*IN_SIZE+j.
- w_data  in  DATA_W  weight read data, 1-cycle latency.
- b_addr  out  clog2(OUT_SIZE)  bias address (current neuron).
- b_data  in  DATA_W  bias read data, 1-cycle latency.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accept.
- out_data  out  DATA_W  signed activated result.
- out_idx  out  clog2(OUT_SIZE)  neuron index of out_data.
- out_last  out  1  high with out_idx==OUT_SIZE-1.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset values (while rst_n low, asynchronous): state IDLE, all counters 0, in_ready=1, out_valid=0, out_data=0, out_idx=0, out_last=0, busy=0, w_addr=0, b_addr=0. Input buffer contents are not cleared.
- IDLE:
  - Each in_valid&&in_ready edge writes in_data to buffer[cnt] and increments cnt.
  - On the IN_SIZE-th accept, go to MAC with neuron=0.
- MAC runs for IN_SIZE+1 cycles, t=0..IN_SIZE:
  - For t<IN_SIZE: w_addr=neuron*IN_SIZE+t, b_addr=neuron.
  - At t=1: acc = (sign-extended b_data <<< FRAC_BITS) + buffer[0]*w_data.
  - At t=2..IN_SIZE: acc += buffer[t-1]*w_data.
  - The full-precision 2*DATA_W product is sign-extended to ACC_W. No accumulator overflow detection.
- MAC to EMIT transition:
  - r = acc >>> FRAC_BITS (floor).
  - Saturate r to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - If RELU=1, negative values become 0.
  - Register the result to out_data; set out_valid=1.
- EMIT:
  - out_data, out_idx and out_last are held stable until out_valid&&out_ready.
  - On that handshake: if neuron==OUT_SIZE-1, go to IDLE with cnt=0 and out_valid=0; else neuron+1 and go to MAC.
- Latency:
  - First out_valid rises IN_SIZE+1 clocks after the final input handshake edge.
  - With out_ready held high, successive out_valid assertions are IN_SIZE+2 cycles apart.
  - Total layer time is OUT_SIZE*(IN_SIZE+2) cycles.
- Boundaries:
  - in_valid outside IDLE is ignored (in_ready=0).
  - out_ready while out_valid=0 is ignored.
  - w_addr and b_addr hold their last value in EMIT and IDLE.
  - Reset mid-MAC or mid-EMIT aborts immediately; no partial result is emitted after release.
  - A new vector may begin the cycle after the final output handshake.

Optional Feature:
- Macro: DENSE_SEQ_ARGMAX_EN.
- Enabled:
  - Adds output ports argmax_valid (1) and argmax_idx (clog2(OUT_SIZE)), plus a running-max register (value and index).
  - Running max resets at each new vector.
  - Compares post-activation out_data; on ties the lower index wins.
  - argmax_valid is high exactly when out_valid&&out_last.
  - argmax_idx includes the final neuron (current out_data compared combinationally against the running max).
  - Both ports reset to 0.
- Disabled: the ports and logic are absent; all other behaviour is identical.

Test Plan (IN_SIZE=4, OUT_SIZE=3, DATA_W=16, FRAC_BITS=8):
1. Basic dot products. x={256,256,256,256} (all 1.0). Row0 weights 256 each, bias 0; row1 weights -256 each, bias 0; row2 weights 0, bias 128.
   - RELU=1: outputs 1024, 0, 128 with out_idx 0,1,2; out_last only on idx 2; argmax_idx=0.
   - RELU=0: row1 gives -1024.
2. Saturation. x and all weights 32767, bias 0 -> out_data 32767. Row with weights -32767, RELU=0 -> -32768.
3. Latency. Final input accepted at edge E with out_ready high -> out_valid first high after edge E+5; next outputs after E+11 and E+17; busy low after the third handshake.
4. Backpressure. out_ready low for 10 cycles during EMIT -> out_valid, out_data, out_idx stable; w_addr unchanged; in_ready=0 throughout.
5. Reset mid-MAC. Pull rst_n low at t=2 of neuron 1 -> out_valid=0 and in_ready=1 asynchronously. A fresh 4-sample vector then produces the full 3-output sequence starting at idx 0.
6. Argmax tie (DENSE_SEQ_ARGMAX_EN). Outputs {500,700,700} -> argmax_idx=1, argmax_valid coincident with out_last handshake only.

Source files
------------

// File: rtl/dense_layer_seq.sv
// Time-multiplexed fully-connected layer: one multiply-accumulate per cycle, valid/ready streaming I/O.
// Define DENSE_SEQ_ARGMAX_EN to add a running argmax over each output vector.
module dense_layer_seq #(
    parameter int IN_SIZE   = 64,
    parameter int OUT_SIZE  = 32,
    parameter int DATA_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int ACC_W     = 40,
    parameter int RELU      = 1,
    localparam int WA_W  = (IN_SIZE * OUT_SIZE > 1) ? $clog2(IN_SIZE * OUT_SIZE) : 1,
    localparam int OI_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic [WA_W-1:0]          w_addr,
    input  logic signed [DATA_W-1:0] w_data,
    output logic [OI_W-1:0]          b_addr,
    input  logic signed [DATA_W-1:0] b_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] out_data,
    output logic [OI_W-1:0]          out_idx,
    output logic                     out_last,
    output logic                     busy
`ifdef DENSE_SEQ_ARGMAX_EN
    ,
    output logic                     argmax_valid,
    output logic [OI_W-1:0]          argmax_idx
`endif
);

    localparam int BI_W  = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
    localparam int CNT_W = $clog2(IN_SIZE + 1);

    localparam logic [BI_W-1:0]  LAST_IN = BI_W'(IN_SIZE - 1);
    localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_LAST  = CNT_W'(IN_SIZE);
    localparam logic [OI_W-1:0]  LAST_N  = OI_W'(OUT_SIZE - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAC,
        S_EMIT
    } state_e;

    state_e                     state_q;
    logic [BI_W-1:0]            cnt_q;
    logic [CNT_W-1:0]           t_q;
    logic [OI_W-1:0]            neuron_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic                       in_ready_q;
    logic                       busy_q;
    logic                       out_valid_q;
    logic signed [DATA_W-1:0]   out_data_q;
    logic [OI_W-1:0]            out_idx_q;
    logic                       out_last_q;
    logic [WA_W-1:0]            w_addr_q;
    logic [OI_W-1:0]            b_addr_q;

    logic signed [DATA_W-1:0]   buf_q [IN_SIZE];

    logic [BI_W-1:0]            rd_idx;
    logic [2*DATA_W-1:0]        a_ext;
    logic [2*DATA_W-1:0]        w_ext;
    logic [2*DATA_W-1:0]        prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    bias_ext;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    r;
    logic signed [DATA_W-1:0]   sat;
    logic signed [DATA_W-1:0]   act;

    // Memory data arrives one cycle after its address, so step t consumes sample t-1.
    assign rd_idx   = BI_W'(t_q - 1'b1);
    assign a_ext    = {{DATA_W{buf_q[rd_idx][DATA_W-1]}}, buf_q[rd_idx]};
    assign w_ext    = {{DATA_W{w_data[DATA_W-1]}}, w_data};
    assign prod     = a_ext * w_ext;
    assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
    assign bias_ext = {{(ACC_W-DATA_W){b_data[DATA_W-1]}}, b_data} <<< FRAC_BITS;

    always_comb begin
        acc_d = acc_q + prod_ext;
        if (t_q == T_ONE) begin
            acc_d = bias_ext + prod_ext;
        end
        r = acc_d >>> FRAC_BITS;
        if (r > SAT_MAX) begin
            sat = SAT_MAX[DATA_W-1:0];
        end else if (r < SAT_MIN) begin
            sat = SAT_MIN[DATA_W-1:0];
        end else begin
            sat = r[DATA_W-1:0];
        end
        act = sat;
        if (RELU != 0 && sat[DATA_W-1]) begin
            act = '0;
        end
    end

    // The sample buffer is plain storage and deliberately survives reset.
    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && in_valid) begin
            buf_q[cnt_q] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            t_q         <= '0;
            neuron_q    <= '0;
            acc_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            w_addr_q    <= '0;
            b_addr_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        if (cnt_q == LAST_IN) begin
                            cnt_q      <= '0;
                            t_q        <= '0;
                            neuron_q   <= '0;
                            w_addr_q   <= '0;
                            b_addr_q   <= '0;
                            in_ready_q <= 1'b0;
                            busy_q     <= 1'b1;
                            state_q    <= S_MAC;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                S_MAC: begin
                    if (t_q != '0) begin
                        acc_q <= acc_d;
                    end
                    if (t_q == T_LAST) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= act;
                        out_idx_q   <= neuron_q;
                        out_last_q  <= (neuron_q == LAST_N);
                        state_q     <= S_EMIT;
                    end else begin
                        t_q <= t_q + 1'b1;
                        if (t_q != T_LAST - 1'b1) begin
                            w_addr_q <= w_addr_q + 1'b1;
                        end
                    end
                end
                S_EMIT: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (neuron_q == LAST_N) begin
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b0;
                            state_q    <= S_IDLE;
                        end else begin
                            neuron_q <= neuron_q + 1'b1;
                            b_addr_q <= neuron_q + 1'b1;
                            w_addr_q <= w_addr_q + 1'b1;
                            t_q      <= '0;
                            state_q  <= S_MAC;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign w_addr    = w_addr_q;
    assign b_addr    = b_addr_q;

`ifdef DENSE_SEQ_ARGMAX_EN
    localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [DATA_W-1:0] max_val_q;
    logic [OI_W-1:0]          max_idx_q;

    // Strict greater-than keeps the lower index on ties; starting at the minimum lets neuron 0 win by default.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val_q <= D_MIN;
            max_idx_q <= '0;
        end else if (state_q == S_IDLE || (state_q == S_EMIT && out_ready && out_last_q)) begin
            max_val_q <= D_MIN;
            max_idx_q <= '0;
        end else if (state_q == S_EMIT && out_ready && out_data_q > max_val_q) begin
            max_val_q <= out_data_q;
            max_idx_q <= out_idx_q;
        end
    end

    assign argmax_valid = out_valid_q && out_last_q;
    assign argmax_idx   = (out_valid_q && out_last_q && out_data_q > max_val_q) ? out_idx_q : max_idx_q;
`endif

endmodule

// File: tb/tb_dense_layer_seq.sv
// Directed bench for dense_layer_seq: a ReLU and a linear instance run in lockstep on shared stimulus.
// Argmax checks are compiled in when DENSE_SEQ_ARGMAX_EN is defined.
module tb_dense_layer_seq;

    logic               clk = 1'b0;
    logic               rstN;
    logic               inValid;
    logic signed [15:0] inData;
    logic               outReady;

    logic [3:0]         reluWAddr, linWAddr;
    logic [1:0]         reluBAddr, linBAddr;
    logic signed [15:0] reluWData, linWData, reluBData, linBData;
    logic               reluInReady, linInReady, reluOutValid, linOutValid;
    logic               reluOutLast, linOutLast, reluBusy, linBusy;
    logic signed [15:0] reluOutData, linOutData;
    logic [1:0]         reluOutIdx, linOutIdx;
`ifdef DENSE_SEQ_ARGMAX_EN
    logic               reluArgValid, linArgValid;
    logic [1:0]         reluArgIdx, linArgIdx;
`endif

    logic signed [15:0] wMem [12];
    logic signed [15:0] bMem [3];

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;
    int edgeE      = 0;
    int riseCyc [3];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        reluWData <= wMem[reluWAddr];
        reluBData <= bMem[reluBAddr];
        linWData  <= wMem[linWAddr];
        linBData  <= bMem[linBAddr];
    end

    dense_layer_seq #(
        .IN_SIZE(4), .OUT_SIZE(3), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU(1)
    ) dutRelu (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid), .in_ready(reluInReady), .in_data(inData),
        .w_addr(reluWAddr), .w_data(reluWData),
        .b_addr(reluBAddr), .b_data(reluBData),
        .out_valid(reluOutValid), .out_ready(outReady), .out_data(reluOutData),
        .out_idx(reluOutIdx), .out_last(reluOutLast), .busy(reluBusy)
`ifdef DENSE_SEQ_ARGMAX_EN
        , .argmax_valid(reluArgValid), .argmax_idx(reluArgIdx)
`endif
    );

    dense_layer_seq #(
        .IN_SIZE(4), .OUT_SIZE(3), .DATA_W(16), .FRAC_BITS(8), .ACC_W(40), .RELU(0)
    ) dutLin (
        .clk(clk), .rst_n(rstN),
        .in_valid(inValid), .in_ready(linInReady), .in_data(inData),
        .w_addr(linWAddr), .w_data(linWData),
        .b_addr(linBAddr), .b_data(linBData),
        .out_valid(linOutValid), .out_ready(outReady), .out_data(linOutData),
        .out_idx(linOutIdx), .out_last(linOutLast), .busy(linBusy)
`ifdef DENSE_SEQ_ARGMAX_EN
        , .argmax_valid(linArgValid), .argmax_idx(linArgIdx)
`endif
    );

    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Every row is uniform, so one weight per neuron describes the whole matrix.
    task automatic loadWeights(input int w0, input int w1, input int w2,
                               input int b0, input int b1, input int b2);
        for (int j = 0; j < 4; j++) begin
            wMem[j]     = 16'(w0);
            wMem[4 + j] = 16'(w1);
            wMem[8 + j] = 16'(w2);
        end
        bMem[0] = 16'(b0);
        bMem[1] = 16'(b1);
        bMem[2] = 16'(b2);
    endtask

    task automatic applyStimulus(input int v0, input int v1, input int v2, input int v3);
        logic signed [15:0] vec [4];
        vec[0] = 16'(v0);
        vec[1] = 16'(v1);
        vec[2] = 16'(v2);
        vec[3] = 16'(v3);
        for (int i = 0; i < 4; i++) begin
            inValid = 1'b1;
            inData  = vec[i];
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        inData  = '0;
    endtask

    task automatic collectOutputs(input int kStart, input int r0, input int r1, input int r2,
                                  input int l0, input int l1, input int l2, input int expArg);
        int er [3];
        int el [3];
        int waitCnt;
        er[0] = r0; er[1] = r1; er[2] = r2;
        el[0] = l0; el[1] = l1; el[2] = l2;
        for (int k = kStart; k < 3; k++) begin
            waitCnt = 0;
            while (reluOutValid !== 1'b1 && waitCnt < 30) begin
                @(posedge clk);
                #1;
                waitCnt++;
            end
            riseCyc[k] = cyc;
            checkOutput("reluOutValid", reluOutValid, 1);
            if (reluOutValid !== 1'b1) return;
            checkOutput("linOutValid", linOutValid, 1);
            checkOutput("reluOutData", reluOutData, er[k]);
            checkOutput("linOutData", linOutData, el[k]);
            checkOutput("outIdx", reluOutIdx, k);
            checkOutput("outLast", reluOutLast, (k == 2) ? 1 : 0);
            checkOutput("linOutLast", linOutLast, (k == 2) ? 1 : 0);
`ifdef DENSE_SEQ_ARGMAX_EN
            checkOutput("argmaxValid", reluArgValid, (k == 2) ? 1 : 0);
            checkOutput("linArgmaxValid", linArgValid, (k == 2) ? 1 : 0);
            if (k == 2) begin
                checkOutput("argmaxIdx", reluArgIdx, expArg);
                checkOutput("linArgmaxIdx", linArgIdx, expArg);
            end
`else
            if (k == 2) checkOutput("lastIdxMatches", linOutIdx, 2 + (expArg - expArg));
`endif
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int waitCnt;
        rstN     = 1'b0;
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        loadWeights(0, 0, 0, 0, 0, 0);

        #12;
        checkOutput("rstInReady", reluInReady, 1);
        checkOutput("rstOutValid", reluOutValid, 0);
        checkOutput("rstBusy", reluBusy, 0);
        checkOutput("rstWAddr", reluWAddr, 0);
        checkOutput("rstBAddr", reluBAddr, 0);
        checkOutput("rstOutData", reluOutData, 0);
        checkOutput("rstOutIdx", reluOutIdx, 0);
        checkOutput("rstOutLast", reluOutLast, 0);
        checkOutput("rstLinBusy", linBusy, 0);
        checkOutput("rstLinInReady", linInReady, 1);
`ifdef DENSE_SEQ_ARGMAX_EN
        checkOutput("rstArgValid", reluArgValid, 0);
        checkOutput("rstArgIdx", reluArgIdx, 0);
`endif
        #5;
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Basic dot products plus output timing.
        $display("[TB] basic dot products and latency");
        loadWeights(256, -256, 0, 0, 0, 128);
        riseCyc = '{0, 0, 0};
        applyStimulus(256, 256, 256, 256);
        edgeE = cyc;
        collectOutputs(0, 1024, 0, 128, 1024, -1024, 128, 0);
        checkOutput("latFirst", riseCyc[0] - edgeE, 5);
        checkOutput("latSecond", riseCyc[1] - edgeE, 11);
        checkOutput("latThird", riseCyc[2] - edgeE, 17);
        checkOutput("busyAfterLast", reluBusy, 0);
        checkOutput("inReadyAfterLast", reluInReady, 1);
        checkOutput("linBusyAfterLast", linBusy, 0);

        // Saturation, started immediately after the final handshake.
        $display("[TB] saturation");
        loadWeights(32767, -32767, 0, 0, 0, 0);
        applyStimulus(32767, 32767, 32767, 32767);
        collectOutputs(0, 32767, 0, 0, 32767, -32768, 0, 0);

        // Backpressure with spurious input traffic while busy.
        $display("[TB] backpressure");
        loadWeights(256, -256, 0, 0, 0, 128);
        outReady = 1'b0;
        applyStimulus(256, 256, 256, 256);
        inValid = 1'b1;
        inData  = 16'sh7fff;
        waitCnt = 0;
        while (reluOutValid !== 1'b1 && waitCnt < 30) begin
            @(posedge clk);
            #1;
            waitCnt++;
        end
        checkOutput("bpValidRise", reluOutValid, 1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            checkOutput("bpInReady", reluInReady, 0);
            checkOutput("bpOutValid", reluOutValid, 1);
        end
        checkOutput("bpOutData", reluOutData, 1024);
        checkOutput("bpOutIdx", reluOutIdx, 0);
        checkOutput("bpWAddr", reluWAddr, 3);
        checkOutput("bpBAddr", reluBAddr, 0);
        inValid  = 1'b0;
        inData   = '0;
        outReady = 1'b1;
        collectOutputs(0, 1024, 0, 128, 1024, -1024, 128, 0);

        // Reset at t=2 of neuron 1, then a fresh vector exercising floor rounding.
        $display("[TB] reset mid-MAC");
        applyStimulus(256, 256, 256, 256);
        repeat (8) @(posedge clk);
        #2;
        rstN = 1'b0;
        #1;
        checkOutput("abortOutValid", reluOutValid, 0);
        checkOutput("abortInReady", reluInReady, 1);
        checkOutput("abortBusy", reluBusy, 0);
        checkOutput("abortBAddr", reluBAddr, 0);
        checkOutput("abortWAddr", reluWAddr, 0);
        @(posedge clk);
        #1;
        rstN = 1'b1;
        loadWeights(-1, 100, -100, 0, 0, 0);
        applyStimulus(1, 1, 1, 1);
        collectOutputs(0, 0, 1, 0, -1, 1, -2, 1);

        // Tie between neurons 1 and 2 resolves to the lower index.
        $display("[TB] argmax tie");
        loadWeights(125, 175, 175, 0, 0, 0);
        applyStimulus(256, 256, 256, 256);
        collectOutputs(0, 500, 700, 700, 500, 700, 700, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
